// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input plus received-byte outputs of the UART receiver.
interface uart_rx_if;
    logic       uart_rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    modport master (output uart_rx, input data_out, rx_valid, frame_err, busy);
    modport slave  (input uart_rx, output data_out, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer and mid-bit sampling.
module uart_rx #(
    parameter int CLK_DIV  = 234,
    parameter int CLK_HALF = 117
) (
    input logic      clk,
    input logic      reset,
    uart_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [8:0] HALF_END = 9'(CLK_HALF - 1);
    localparam logic [8:0] BIT_END  = 9'(CLK_DIV - 1);
    state_t     state_q, state_d;
    logic       sync_q, rx_s_q, rx_d_q;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= bus.uart_rx;
            rx_s_q  <= sync_q;
            rx_d_q  <= rx_s_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Pulses are registered so rx_valid rises in the same cycle data_out changes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s_q) state_d = START;
            end
            START: begin
                cnt_d = (cnt_q == HALF_END) ? '0 : cnt_q + 9'd1;
                idx_d = '0;
                if (cnt_q == HALF_END) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                cnt_d = (cnt_q == BIT_END) ? '0 : cnt_q + 9'd1;
                if (cnt_q == BIT_END) begin
                    shift_d[idx_q] = rx_s_q;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = (cnt_q == BIT_END) ? '0 : cnt_q + 9'd1;
                if (cnt_q == BIT_END) begin
                    state_d = IDLE;
                    valid_d = rx_s_q;
                    ferr_d  = !rx_s_q;
                    data_d  = rx_s_q ? shift_q : data_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, randomized and corner-case checks of the UART receiver.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset;
    uart_rx_if bus ();

    uart_rx dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                vcnt++;
                vq.push_back(bus.data_out);
            end
            if (bus.frame_err) ecnt++;
            if (bus.rx_valid && bus.frame_err) both++;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         per;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name, input logic [7:0] exp);
        logic [7:0] got;
        if (vq.size() == 0) begin
            check(name, 32'hdead, {24'h0, exp});
        end else begin
            got = vq.pop_front();
            check(name, {24'h0, got}, {24'h0, exp});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int p);
        bus.uart_rx = b;
        idle(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        send_bit(stop, p);
    endtask

    vec_t vecs[6];
    logic [7:0] model_data;

    initial begin
        int v0, e0;
        logic [7:0] rd;
        logic rs;
        int rp;
        vecs[0] = '{8'hA5, 1'b1, 234, 1, 0, 8'hA5};
        vecs[1] = '{8'hC3, 1'b1, 231, 1, 0, 8'hC3};
        vecs[2] = '{8'hC3, 1'b1, 237, 1, 0, 8'hC3};
        vecs[3] = '{8'h12, 1'b0, 234, 0, 1, 8'hC3};
        vecs[4] = '{8'h01, 1'b1, 234, 1, 0, 8'h01};
        vecs[5] = '{8'h80, 1'b1, 236, 1, 0, 8'h80};

        reset = 1'b1;
        bus.uart_rx = 1'b1;
        idle(3);
        check("rst_data", {24'h0, bus.data_out}, 32'h00);
        check("rst_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        reset = 1'b0;
        idle(10);

        foreach (vecs[k]) begin
            v0 = vcnt;
            e0 = ecnt;
            send_frame(vecs[k].d, vecs[k].stop, vecs[k].per);
            bus.uart_rx = 1'b1;
            idle(40);
            check($sformatf("vec%0d_valid", k), vcnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k), ecnt - e0, vecs[k].exp_err);
            check($sformatf("vec%0d_data", k), {24'h0, bus.data_out}, {24'h0, vecs[k].exp_data});
            check($sformatf("vec%0d_busy", k), {31'h0, bus.busy}, 32'h0);
            if (vecs[k].exp_valid == 1) check_pop($sformatf("vec%0d_cap", k), vecs[k].exp_data);
        end

        model_data = bus.data_out;
        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rp = $urandom_range(231, 237);
            v0 = vcnt;
            e0 = ecnt;
            send_frame(rd, rs, rp);
            bus.uart_rx = 1'b1;
            idle(40);
            if (rs) model_data = rd;
            check($sformatf("rnd%0d_valid", k), vcnt - v0, {31'h0, rs});
            check($sformatf("rnd%0d_ferr", k), ecnt - e0, {31'h0, !rs});
            check($sformatf("rnd%0d_data", k), {24'h0, bus.data_out}, {24'h0, model_data});
            if (rs) check_pop($sformatf("rnd%0d_cap", k), rd);
        end

        v0 = vcnt;
        send_frame(8'h00, 1'b1, 234);
        send_frame(8'hFF, 1'b1, 234);
        send_frame(8'h55, 1'b1, 234);
        idle(40);
        check("b2b_count", vcnt - v0, 3);
        check_pop("b2b_0", 8'h00);
        check_pop("b2b_1", 8'hFF);
        check_pop("b2b_2", 8'h55);

        v0 = vcnt;
        e0 = ecnt;
        bus.uart_rx = 1'b0;
        idle(100);
        bus.uart_rx = 1'b1;
        idle(30);
        check("glitch_busy", {31'h0, bus.busy}, 32'h0);
        idle(300);
        check("glitch_valid", vcnt - v0, 0);
        check("glitch_ferr", ecnt - e0, 0);

        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h3C, 1'b0, 234);
        idle(5000);
        check("brk_ferr", ecnt - e0, 1);
        check("brk_valid", vcnt - v0, 0);
        check("brk_data", {24'h0, bus.data_out}, 32'h55);
        check("brk_busy", {31'h0, bus.busy}, 32'h0);
        bus.uart_rx = 1'b1;
        idle(50);
        send_frame(8'h5A, 1'b1, 234);
        idle(40);
        check("brk_next", {24'h0, bus.data_out}, 32'h5A);
        check_pop("brk_cap", 8'h5A);

        v0 = vcnt;
        e0 = ecnt;
        send_bit(1'b0, 234);
        send_bit(1'b1, 234);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 234);
        bus.uart_rx = 1'b0;
        idle(100);
        check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        reset = 1'b1;
        bus.uart_rx = 1'b1;
        #2;
        check("mid_rst_data", {24'h0, bus.data_out}, 32'h00);
        check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("mid_rst_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("mid_rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        idle(5);
        reset = 1'b0;
        idle(300);
        check("post_rst_quiet", (vcnt - v0) + (ecnt - e0), 0);
        send_frame(8'h7E, 1'b1, 234);
        idle(40);
        check("post_rst_valid", vcnt - v0, 1);
        check("post_rst_data", {24'h0, bus.data_out}, 32'h7E);
        check_pop("post_rst_cap", 8'h7E);

        check("no_overlap", both, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
